masku_operand_sequencer: RTL and testbench

Sequences mask-unit operand consumption for one mask instruction at a time. It accepts an instruction descriptor (vl, element width, which operands are used), waits until every required operand queue in every lane holds data, and then presents one datapath beat to the mask-unit execution stage. On each accepted beat it pops all required operands from all lanes in lockstep and tracks remaining elements. It sits between the lane operand queues and the mask-unit operand/execute logic.

---
 rtl/masku_operand_sequencer_if.sv | 40 ++++
 rtl/masku_operand_sequencer.sv | 106 ++++++++++
 tb/tb_masku_operand_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/masku_operand_sequencer_if.sv
// Handshake bundle between the mask-unit operand sequencer, the lane operand
// queues and the mask-unit execute stage.
interface masku_operand_sequencer_if #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned VlWidth = 16
);
  logic                   start_valid_i;
  logic                   start_ready_o;
  logic [VlWidth-1:0]     start_vl_i;
  logic [1:0]             start_eew_i;
  logic                   start_use_a_i;
  logic                   start_use_b_i;
  logic                   start_use_m_i;
  logic [NrLanes*3-1:0]   op_valid_i;
  logic [NrLanes*3-1:0]   op_ready_o;
  logic                   beat_valid_o;
  logic                   beat_ready_i;
  logic [VlWidth-1:0]     beat_vl_o;
  logic                   beat_first_o;
  logic                   beat_last_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   flush_i;

  modport slave (
    input  start_valid_i, start_vl_i, start_eew_i,
    input  start_use_a_i, start_use_b_i, start_use_m_i,
    input  op_valid_i, beat_ready_i, flush_i,
    output start_ready_o, op_ready_o, beat_valid_o, beat_vl_o,
    output beat_first_o, beat_last_o, busy_o, done_o
  );

  modport master (
    output start_valid_i, start_vl_i, start_eew_i,
    output start_use_a_i, start_use_b_i, start_use_m_i,
    output op_valid_i, beat_ready_i, flush_i,
    input  start_ready_o, op_ready_o, beat_valid_o, beat_vl_o,
    input  beat_first_o, beat_last_o, busy_o, done_o
  );
endinterface

// File: rtl/masku_operand_sequencer.sv
// Sequences lockstep operand pops across all lanes for one mask instruction,
// emitting one execute beat per cycle while every required queue holds data.
module masku_operand_sequencer #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned ELEN    = 64,
  parameter int unsigned VlWidth = 16
) (
  input logic                      clk_i,
  input logic                      rst_i,
  masku_operand_sequencer_if.slave io
);

  localparam int unsigned OpW = NrLanes * 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [VlWidth-1:0] rem_q, epb_q, beat_vl;
  logic               first_q, use_a_q, use_b_q, use_m_q;
  logic               in_run, req_ok, start_fire, fire, last;
  logic [OpW-1:0]     op_ready;

  function automatic logic [VlWidth-1:0] calc_epb(input logic [1:0] eew);
    return VlWidth'(NrLanes * ((ELEN / 8) >> eew));
  endfunction

  // Clamp the beat to the elements still outstanding.
  function automatic logic [VlWidth-1:0] sat_beat_vl(input logic [VlWidth-1:0] rem,
                                                     input logic [VlWidth-1:0] epb);
    return (rem < epb) ? rem : epb;
  endfunction

  assign in_run     = (state_q == RUN);
  assign start_fire = (state_q == IDLE) & io.start_valid_i & ~io.flush_i;
  assign last       = (rem_q <= epb_q);
  assign beat_vl    = sat_beat_vl(rem_q, epb_q);

  // Unused operands are treated as always present.
  always_comb begin
    req_ok = 1'b1;
    for (int l = 0; l < NrLanes; l++) begin
      req_ok &= (io.op_valid_i[l*3+0] | ~use_m_q) &
                (io.op_valid_i[l*3+1] | ~use_b_q) &
                (io.op_valid_i[l*3+2] | ~use_a_q);
    end
  end

  assign fire = in_run & req_ok & io.beat_ready_i & ~io.flush_i & ~rst_i;

  always_comb begin
    op_ready = '0;
    for (int l = 0; l < NrLanes; l++) begin
      op_ready[l*3+0] = fire & use_m_q;
      op_ready[l*3+1] = fire & use_b_q;
      op_ready[l*3+2] = fire & use_a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_fire) state_d = (io.start_vl_i == '0) ? DONE : RUN;
      RUN:     if (fire && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q   <= '0;
      epb_q   <= '0;
      first_q <= 1'b0;
      use_a_q <= 1'b0;
      use_b_q <= 1'b0;
      use_m_q <= 1'b0;
    end else if (start_fire) begin
      rem_q   <= io.start_vl_i;
      epb_q   <= calc_epb(io.start_eew_i);
      first_q <= 1'b1;
      use_a_q <= io.start_use_a_i;
      use_b_q <= io.start_use_b_i;
      use_m_q <= io.start_use_m_i;
    end else if (fire) begin
      rem_q   <= rem_q - beat_vl;
      first_q <= 1'b0;
    end
  end

  // Beat descriptors come only from registered state; validity tracks the queues.
  assign io.start_ready_o = (state_q == IDLE) & ~io.flush_i;
  assign io.beat_valid_o  = in_run & req_ok & ~io.flush_i & ~rst_i;
  assign io.op_ready_o    = op_ready;
  assign io.beat_vl_o     = in_run ? beat_vl : '0;
  assign io.beat_first_o  = in_run & first_q;
  assign io.beat_last_o   = in_run & last;
  assign io.busy_o        = (state_q != IDLE);
  assign io.done_o        = (state_q == DONE) & ~io.flush_i & ~rst_i;

endmodule

// File: tb/tb_masku_operand_sequencer.sv
// Randomized bench for masku_operand_sequencer against a beat-list model.
module tb_masku_operand_sequencer;
  localparam int NrLanes = 4;
  localparam int VlWidth = 16;
  localparam int OpW     = NrLanes * 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  masku_operand_sequencer_if #(.NrLanes(NrLanes), .VlWidth(VlWidth)) bus ();

  masku_operand_sequencer #(.NrLanes(NrLanes), .ELEN(64), .VlWidth(VlWidth)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vl;
    bit first;
    bit last;
  } beat_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OpW-1:0] use_mask(input bit ua, input bit ub, input bit um);
    logic [OpW-1:0] m;
    m = '0;
    for (int l = 0; l < NrLanes; l++) begin
      m[l*3+0] = um;
      m[l*3+1] = ub;
      m[l*3+2] = ua;
    end
    return m;
  endfunction

  // Lane bits divided by element bits.
  function automatic int elems_per_beat(input int eew);
    return NrLanes * 64 / (8 << eew);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cycle(input int vl, input int eew, input bit ua, input bit ub, input bit um);
    bus.start_valid_i = 1'b1;
    bus.start_vl_i    = VlWidth'(vl);
    bus.start_eew_i   = 2'(eew);
    bus.start_use_a_i = ua;
    bus.start_use_b_i = ub;
    bus.start_use_m_i = um;
    bus.flush_i       = 1'b0;
    bus.op_valid_i    = OpW'($urandom);
    bus.beat_ready_i  = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_start_ready", 32'(bus.start_ready_o), 1);
    chk("idle_busy", 32'(bus.busy_o), 0);
    chk("idle_beat_valid", 32'(bus.beat_valid_o), 0);
    chk("idle_op_ready", 32'(bus.op_ready_o), 0);
    chk("idle_done", 32'(bus.done_o), 0);
    tick();
    bus.start_valid_i = 1'b0;
    bus.start_vl_i    = VlWidth'($urandom);
    bus.start_eew_i   = 2'($urandom);
    bus.start_use_a_i = 1'($urandom);
    bus.start_use_b_i = 1'($urandom);
    bus.start_use_m_i = 1'($urandom);
  endtask

  // mode 0: ideal, 1: random stalls, 2: lane-2 M empty 3 cycles then ready low 2 cycles
  task automatic run_instr(input int vl, input int eew, input bit ua, input bit ub,
                           input bit um, input int mode);
    beat_t          q[$];
    int             rem;
    bit             first;
    int             epb;
    int             c;
    logic [OpW-1:0] mask;
    rem   = vl;
    first = 1'b1;
    epb   = elems_per_beat(eew);
    mask  = use_mask(ua, ub, um);
    c     = 0;
    while (rem > 0) begin
      beat_t b;
      b.vl    = (rem < epb) ? rem : epb;
      b.first = first;
      b.last  = (rem <= epb);
      q.push_back(b);
      rem   -= b.vl;
      first  = 1'b0;
    end
    start_cycle(vl, eew, ua, ub, um);
    while (q.size() > 0) begin
      logic [OpW-1:0] ov;
      bit             br, ok, f;
      if (c >= 500) begin
        chk("beat_timeout", 32'(q.size()), 0);
        break;
      end
      ov = '1;
      br = 1'b1;
      if (mode == 1) begin
        if ($urandom_range(0, 3) == 0) ov = OpW'($urandom);
        br = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        if (c < 3) ov[6] = 1'b0;
        else if (c < 5) br = 1'b0;
      end
      bus.op_valid_i   = ov;
      bus.beat_ready_i = br;
      ok = ((ov & mask) == mask);
      f  = ok & br;
      @(negedge clk);
      chk("beat_valid", 32'(bus.beat_valid_o), 32'(ok));
      chk("beat_vl", 32'(bus.beat_vl_o), q[0].vl);
      chk("beat_first", 32'(bus.beat_first_o), 32'(q[0].first));
      chk("beat_last", 32'(bus.beat_last_o), 32'(q[0].last));
      chk("op_ready", 32'(bus.op_ready_o), f ? 32'(mask) : 32'd0);
      chk("run_busy", 32'(bus.busy_o), 1);
      chk("run_done", 32'(bus.done_o), 0);
      chk("run_start_ready", 32'(bus.start_ready_o), 0);
      tick();
      if (f) q.delete(0);
      c++;
    end
    bus.op_valid_i   = OpW'($urandom);
    bus.beat_ready_i = 1'($urandom);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done_o), 1);
    chk("done_busy", 32'(bus.busy_o), 1);
    chk("done_beat_valid", 32'(bus.beat_valid_o), 0);
    chk("done_op_ready", 32'(bus.op_ready_o), 0);
    chk("done_start_ready", 32'(bus.start_ready_o), 0);
    tick();
  endtask

  // Starts vl=16/EPB=4 with all operands and fires the first beat.
  task automatic start_and_one_beat();
    start_cycle(16, 3, 1'b1, 1'b1, 1'b1);
    bus.op_valid_i   = '1;
    bus.beat_ready_i = 1'b1;
    @(negedge clk);
    chk("b1_vl", 32'(bus.beat_vl_o), 4);
    chk("b1_pop", 32'(bus.op_ready_o), 32'hfff);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    bus.start_valid_i = 1'b0;
    bus.start_vl_i    = '0;
    bus.start_eew_i   = '0;
    bus.start_use_a_i = 1'b0;
    bus.start_use_b_i = 1'b0;
    bus.start_use_m_i = 1'b0;
    bus.op_valid_i    = '1;
    bus.beat_ready_i  = 1'b1;
    bus.flush_i       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", 32'(bus.start_ready_o), 1);
    chk("rst_beat_valid", 32'(bus.beat_valid_o), 0);
    chk("rst_op_ready", 32'(bus.op_ready_o), 0);
    chk("rst_beat_vl", 32'(bus.beat_vl_o), 0);
    chk("rst_first", 32'(bus.beat_first_o), 0);
    chk("rst_last", 32'(bus.beat_last_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    tick();

    run_instr(10, 3, 1'b1, 1'b1, 1'b1, 0);
    run_instr(32, 0, 1'b1, 1'b0, 1'b0, 0);
    run_instr(0, 2, 1'b1, 1'b1, 1'b1, 0);
    run_instr(8, 3, 1'b1, 1'b1, 1'b1, 2);

    // Flush during beat 2, then an immediate new start.
    start_and_one_beat();
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_pop", 32'(bus.op_ready_o), 0);
    chk("flush_done", 32'(bus.done_o), 0);
    tick();
    bus.flush_i = 1'b0;
    run_instr(5, 2, 1'b1, 1'b0, 1'b1, 0);

    // Reset while running.
    start_and_one_beat();
    rst = 1'b1;
    @(negedge clk);
    chk("rstrun_pop", 32'(bus.op_ready_o), 0);
    chk("rstrun_done", 32'(bus.done_o), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstrun_start_ready", 32'(bus.start_ready_o), 1);
    chk("rstrun_beat_valid", 32'(bus.beat_valid_o), 0);
    chk("rstrun_op_ready", 32'(bus.op_ready_o), 0);
    chk("rstrun_beat_vl", 32'(bus.beat_vl_o), 0);
    chk("rstrun_first", 32'(bus.beat_first_o), 0);
    chk("rstrun_last", 32'(bus.beat_last_o), 0);
    chk("rstrun_busy", 32'(bus.busy_o), 0);
    chk("rstrun_done", 32'(bus.done_o), 0);
    tick();

    for (int i = 0; i < 40; i++) begin
      run_instr($urandom_range(0, 70), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
